regfile2in_loader: RTL and testbench

REGFILE2IN_LOADER -- requirements
Module: regfile2in_loader

---
 rtl/img2col_pkg.sv | 16 +
 rtl/regfile2in_addr_gen.sv | 52 +++++
 rtl/regfile2in_loader.sv | 148 ++++++++++++++
 tb/tb_regfile2in_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// Shared state encoding and default sizing for the img2col register-file loader blocks.
package img2col_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int REG_NUM_DEF     = 25;
    localparam int ADDRESS_NUM_DEF = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/regfile2in_addr_gen.sv
// Pair write pointer for the loader: clears on a new window, steps by two per accepted beat,
// and flags the final beat and the odd single-word tail.
module regfile2in_addr_gen
    import img2col_pkg::*;
#(
    parameter int reg_num     = REG_NUM_DEF,
    parameter int address_num = ADDRESS_NUM_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    output logic [address_num-1:0] ptr,
    output logic [address_num-1:0] ptr_plus1,
    output logic                   last_beat,
    output logic                   odd_tail
);

    localparam int CW = address_num + 1;
    localparam logic [CW-1:0] LIMIT = CW'(reg_num);
    localparam logic [CW-1:0] TAIL  = CW'(reg_num - 1);
    localparam bit REG_NUM_ODD      = (reg_num % 2) != 0;

    logic [address_num-1:0] ptr_q;
    logic [address_num-1:0] ptr_d;
    logic [CW-1:0]          ptr_wide;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (advance) begin
            ptr_d = ptr_q + address_num'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // One extra bit so the compare near the top of the address space cannot wrap.
    assign ptr_wide  = {1'b0, ptr_q};
    assign ptr       = ptr_q;
    assign ptr_plus1 = ptr_q + address_num'(1);
    assign last_beat = (ptr_wide + CW'(2)) >= LIMIT;
    assign odd_tail  = REG_NUM_ODD && (ptr_wide == TAIL);

endmodule

// File: rtl/regfile2in_loader.sv
// Loads one register-file window from a two-word stream, then pulses the parallel read and done.
// Define REGFILE2IN_LOADER_ABORT_EN to add an abort input that drops the current window.
module regfile2in_loader
    import img2col_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH_DEF,
    parameter int reg_num     = REG_NUM_DEF,
    parameter int address_num = ADDRESS_NUM_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef REGFILE2IN_LOADER_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [data_width-1:0]  in_data1,
    input  logic [data_width-1:0]  in_data2,
    output logic [data_width-1:0]  in1,
    output logic [data_width-1:0]  in2,
    output logic [address_num-1:0] adrs_in1,
    output logic [address_num-1:0] adrs_in2,
    output logic                   wr_ctrl,
    output logic                   r_ctrl,
    output logic                   busy,
    output logic                   done
);

    loader_state_e state_q;
    loader_state_e state_d;

    logic [data_width-1:0]  in1_q;
    logic [data_width-1:0]  in1_d;
    logic [data_width-1:0]  in2_q;
    logic [data_width-1:0]  in2_d;
    logic [address_num-1:0] adrs1_q;
    logic [address_num-1:0] adrs1_d;
    logic [address_num-1:0] adrs2_q;
    logic [address_num-1:0] adrs2_d;
    logic                   wr_ctrl_q;
    logic                   wr_ctrl_d;

    logic                   abort_req;
    logic                   accept;
    logic                   clear_ptr;
    logic                   last_beat;
    logic                   odd_tail;
    logic [address_num-1:0] ptr;
    logic [address_num-1:0] ptr_plus1;

`ifdef REGFILE2IN_LOADER_ABORT_EN
    assign abort_req = abort && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    regfile2in_addr_gen #(
        .reg_num     (reg_num),
        .address_num (address_num)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_ptr),
        .advance   (accept),
        .ptr       (ptr),
        .ptr_plus1 (ptr_plus1),
        .last_beat (last_beat),
        .odd_tail  (odd_tail)
    );

    // Refusing the handshake during abort keeps the offered beat and the write port untouched.
    assign in_ready = (state_q == FILL) && !abort_req;

    always_comb begin
        state_d   = state_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        adrs1_d   = adrs1_q;
        adrs2_d   = adrs2_q;
        wr_ctrl_d = 1'b0;
        accept    = 1'b0;
        clear_ptr = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    clear_ptr = 1'b1;
                end
            end
            FILL: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    wr_ctrl_d = 1'b1;
                    in1_d     = in_data1;
                    adrs1_d   = ptr;
                    if (odd_tail) begin
                        in2_d   = in_data1;
                        adrs2_d = ptr;
                    end else begin
                        in2_d   = in_data2;
                        adrs2_d = ptr_plus1;
                    end
                    if (last_beat) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = READ;
            READ:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_req) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in1_q     <= '0;
            in2_q     <= '0;
            adrs1_q   <= '0;
            adrs2_q   <= '0;
            wr_ctrl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            adrs1_q   <= adrs1_d;
            adrs2_q   <= adrs2_d;
            wr_ctrl_q <= wr_ctrl_d;
        end
    end

    assign in1      = in1_q;
    assign in2      = in2_q;
    assign adrs_in1 = adrs1_q;
    assign adrs_in2 = adrs2_q;
    assign wr_ctrl  = wr_ctrl_q;
    assign r_ctrl   = (state_q == READ);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_regfile2in_loader.sv
// Randomized directed bench for regfile2in_loader: an odd (5) and an even (4) window instance
// checked against a word-level register-file model.
module tb_regfile2in_loader;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int RN0 = 5;
    localparam int RN1 = 4;

    typedef struct {
        int            unit;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start     [2];
    logic          in_valid  [2];
    logic [DW-1:0] d1_i      [2];
    logic [DW-1:0] d2_i      [2];
    logic          in_ready_o[2];
    logic [DW-1:0] in1_o     [2];
    logic [DW-1:0] in2_o     [2];
    logic [AW-1:0] a1_o      [2];
    logic [AW-1:0] a2_o      [2];
    logic          wr_o      [2];
    logic          r_o       [2];
    logic          busy_o    [2];
    logic          done_o    [2];
`ifdef REGFILE2IN_LOADER_ABORT_EN
    logic          abort     [2];
`endif

    int            checks;
    int            failures;
    wr_t           exp_q[$];
    logic [DW-1:0] rf      [2][32];
    logic [DW-1:0] exp_mem [2][32];
    logic          prev_r  [2];
    logic          prev_wr [2];
    logic [63:0]   prev_port[2];
    int            done_cnt[2];
    int            r_cnt   [2];

    regfile2in_loader #(.data_width(DW), .reg_num(RN0), .address_num(AW)) dut_odd (
        .clk      (clk),
        .rst      (rst),
`ifdef REGFILE2IN_LOADER_ABORT_EN
        .abort    (abort[0]),
`endif
        .start    (start[0]),
        .in_valid (in_valid[0]),
        .in_ready (in_ready_o[0]),
        .in_data1 (d1_i[0]),
        .in_data2 (d2_i[0]),
        .in1      (in1_o[0]),
        .in2      (in2_o[0]),
        .adrs_in1 (a1_o[0]),
        .adrs_in2 (a2_o[0]),
        .wr_ctrl  (wr_o[0]),
        .r_ctrl   (r_o[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0])
    );

    regfile2in_loader #(.data_width(DW), .reg_num(RN1), .address_num(AW)) dut_even (
        .clk      (clk),
        .rst      (rst),
`ifdef REGFILE2IN_LOADER_ABORT_EN
        .abort    (abort[1]),
`endif
        .start    (start[1]),
        .in_valid (in_valid[1]),
        .in_ready (in_ready_o[1]),
        .in_data1 (d1_i[1]),
        .in_data2 (d2_i[1]),
        .in1      (in1_o[1]),
        .in2      (in2_o[1]),
        .adrs_in1 (a1_o[1]),
        .adrs_in2 (a2_o[1]),
        .wr_ctrl  (wr_o[1]),
        .r_ctrl   (r_o[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1])
    );

    function automatic int rn_of(input int u);
        return (u == 0) ? RN0 : RN1;
    endfunction

    function automatic logic [63:0] port_word(input int u);
        return 64'({a1_o[u], a2_o[u], in1_o[u], in2_o[u]});
    endfunction

    function automatic logic [63:0] all_outputs(input int u);
        return 64'({in1_o[u], in2_o[u], a1_o[u], a2_o[u], wr_o[u], r_o[u],
                    in_ready_o[u], busy_o[u], done_o[u]});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock, then per-cycle protocol checks and register-file model update on both units.
    task automatic tick();
        logic rst_edge;
        wr_t  e;
        rst_edge = rst;
        @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput("wr_r_exclusive", 64'(wr_o[u] & r_o[u]), 64'd0);
            if (done_o[u]) begin
                checkOutput("done_after_read", 64'(prev_r[u]), 64'd1);
                done_cnt[u]++;
            end
            if (r_o[u]) begin
                checkOutput("read_after_last_write", 64'(prev_wr[u]), 64'd1);
                r_cnt[u]++;
            end
            if (wr_o[u]) begin
                checkOutput("write_expected", 64'(exp_q.size() > 0 && exp_q[0].unit == u), 64'd1);
                if (exp_q.size() > 0 && exp_q[0].unit == u) begin
                    e = exp_q.pop_front();
                    checkOutput("write_pair", port_word(u), 64'({e.a1, e.a2, e.w1, e.w2}));
                end
                rf[u][a1_o[u]] = in1_o[u];
                rf[u][a2_o[u]] = in2_o[u];
            end else if (!rst_edge) begin
                checkOutput("hold_when_idle_write", port_word(u), prev_port[u]);
            end
            prev_r[u]    = r_o[u];
            prev_wr[u]   = wr_o[u];
            prev_port[u] = port_word(u);
        end
    endtask

    task automatic applyStimulus(input int u, input logic st, input logic v,
                                 input logic [DW-1:0] w1, input logic [DW-1:0] w2);
        for (int k = 0; k < 2; k++) begin
            start[k]    = 1'b0;
            in_valid[k] = 1'b0;
            d1_i[k]     = '0;
            d2_i[k]     = '0;
        end
        start[u]    = st;
        in_valid[u] = v;
        d1_i[u]     = w1;
        d2_i[u]     = w2;
        tick();
    endtask

    // Queue the expected write for beat k and record the words the window should end up holding.
    task automatic expect_beat(input int u, input int k, input logic [DW-1:0] w1, input logic [DW-1:0] w2);
        wr_t e;
        int  rn;
        rn     = rn_of(u);
        e.unit = u;
        e.a1   = AW'(2 * k);
        e.w1   = w1;
        exp_mem[u][2 * k] = w1;
        if (2 * k + 1 < rn) begin
            e.a2 = AW'(2 * k + 1);
            e.w2 = w2;
            exp_mem[u][2 * k + 1] = w2;
        end else begin
            e.a2 = AW'(2 * k);
            e.w2 = w1;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_window(input int u, input int fix_stall, input bit noisy);
        int            rn;
        int            beats;
        int            base_done;
        int            waited;
        int            stalls;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        rn        = rn_of(u);
        beats     = (rn + 1) / 2;
        base_done = done_cnt[u];
        applyStimulus(u, 1'b1, 1'b0, '0, '0);
        checkOutput("busy_after_start", 64'(busy_o[u]), 64'd1);
        for (int k = 0; k < beats; k++) begin
            stalls = (k == 0) ? 0 : ((fix_stall >= 0) ? fix_stall : int'($urandom_range(3, 0)));
            for (int s = 0; s < stalls; s++) begin
                applyStimulus(u, noisy, 1'b0, DW'($urandom), DW'($urandom));
            end
            w1 = DW'($urandom);
            w2 = DW'($urandom);
            checkOutput("in_ready_in_fill", 64'(in_ready_o[u]), 64'd1);
            expect_beat(u, k, w1, w2);
            applyStimulus(u, noisy, 1'b1, w1, w2);
        end
        waited = 0;
        while (!done_o[u] && waited < 8) begin
            applyStimulus(u, noisy && r_o[u], 1'b0, '0, '0);
            waited++;
        end
        checkOutput("done_latency", 64'(waited), 64'd2);
        checkOutput("done_count", 64'(done_cnt[u] - base_done), 64'd1);
        for (int i = 0; i < rn; i++) begin
            checkOutput("regfile_word", 64'(rf[u][i]), 64'(exp_mem[u][i]));
        end
        applyStimulus(u, 1'b0, 1'b0, '0, '0);
        checkOutput("idle_after_done", 64'({busy_o[u], in_ready_o[u]}), 64'd0);
        checkOutput("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int            base;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        checks   = 0;
        failures = 0;
        for (int u = 0; u < 2; u++) begin
            prev_r[u]    = 1'b0;
            prev_wr[u]   = 1'b0;
            prev_port[u] = '0;
            done_cnt[u]  = 0;
            r_cnt[u]     = 0;
            for (int i = 0; i < 32; i++) begin
                rf[u][i]      = '0;
                exp_mem[u][i] = '0;
            end
`ifdef REGFILE2IN_LOADER_ABORT_EN
            abort[u] = 1'b0;
`endif
        end

        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, DW'($urandom), DW'($urandom));
        checkOutput("reset_outputs_odd", all_outputs(0), 64'd0);
        checkOutput("reset_outputs_even", all_outputs(1), 64'd0);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);

        $display("[TB] odd window, back-to-back beats");
        run_window(0, 0, 1'b0);
        $display("[TB] even window, valid pattern 1,0,0,1");
        run_window(1, 2, 1'b0);
        $display("[TB] start pulses during FILL and READ");
        run_window(0, -1, 1'b1);
        run_window(1, -1, 1'b1);

        $display("[TB] reset after one beat");
        applyStimulus(0, 1'b1, 1'b0, '0, '0);
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        expect_beat(0, 0, w1, w2);
        applyStimulus(0, 1'b0, 1'b1, w1, w2);
        base = done_cnt[0];
        rst  = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, DW'($urandom), DW'($urandom));
        checkOutput("reset_mid_window", all_outputs(0), 64'd0);
        rst = 1'b0;
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0, '0);
        checkOutput("reset_no_done", 64'(done_cnt[0] - base), 64'd0);
        run_window(0, -1, 1'b0);

        $display("[TB] randomized windows");
        for (int n = 0; n < 6; n++) begin
            run_window(n % 2, -1, bit'($urandom_range(1, 0)));
        end

`ifdef REGFILE2IN_LOADER_ABORT_EN
        $display("[TB] abort after two beats");
        applyStimulus(0, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            w1 = DW'($urandom);
            w2 = DW'($urandom);
            expect_beat(0, k, w1, w2);
            applyStimulus(0, 1'b0, 1'b1, w1, w2);
        end
        base        = r_cnt[0];
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        d1_i[0]     = DW'($urandom);
        d2_i[0]     = DW'($urandom);
        abort[0]    = 1'b1;
        tick();
        abort[0]    = 1'b0;
        checkOutput("abort_to_idle", 64'({busy_o[0], in_ready_o[0], wr_o[0], r_o[0], done_o[0]}), 64'd0);
        repeat (3) applyStimulus(0, 1'b0, 1'b0, '0, '0);
        checkOutput("abort_no_read", 64'(r_cnt[0] - base), 64'd0);
        run_window(0, -1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
